// File: rtl/flag_offset_encoder_pkg.sv
// Shared defaults, log2 helper macro and FSM encoding for the flag/offset sparsity encoder.
// Optional magnitude pruning is enabled by defining FLGOFFSET_ENC_THRESH_EN.
`ifndef C_LOG_2
`define C_LOG_2(n) (((n) <= 1) ? 1 : $clog2(n))
`endif

package flag_offset_encoder_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefActWidth  = 8;
  localparam int unsigned DefPackNum   = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StFlush   = 2'd2,
    StEmit    = 2'd3
  } enc_state_e;

endpackage

// File: rtl/flag_offset_encoder_if.sv
// Handshake bundle for the flag/offset encoder: dense input, packed word output, flag output.
// I_Thr exists only when FLGOFFSET_ENC_THRESH_EN is defined.
interface flag_offset_encoder_if
  import flag_offset_encoder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ACT_WIDTH  = DefActWidth,
  parameter int unsigned PACK_NUM   = DefPackNum
) ();

  logic                          I_Sta;
  logic                          I_Dat_val;
  logic [ACT_WIDTH-1:0]          I_Dat;
  logic                          O_Dat_rdy;
  logic [PACK_NUM*ACT_WIDTH-1:0] O_Word;
  logic                          O_Word_val;
  logic                          I_Word_rdy;
  logic [DATA_WIDTH-1:0]         O_Flag;
  logic                          O_Flag_val;
  logic                          I_Flag_rdy;
  logic                          O_fnh;
`ifdef FLGOFFSET_ENC_THRESH_EN
  logic [ACT_WIDTH-2:0]          I_Thr;
`endif

  modport master (
    output I_Sta, I_Dat_val, I_Dat, I_Word_rdy, I_Flag_rdy,
`ifdef FLGOFFSET_ENC_THRESH_EN
    output I_Thr,
`endif
    input  O_Dat_rdy, O_Word, O_Word_val, O_Flag, O_Flag_val, O_fnh
  );

  modport slave (
    input  I_Sta, I_Dat_val, I_Dat, I_Word_rdy, I_Flag_rdy,
`ifdef FLGOFFSET_ENC_THRESH_EN
    input  I_Thr,
`endif
    output O_Dat_rdy, O_Word, O_Word_val, O_Flag, O_Flag_val, O_fnh
  );

endinterface

// File: rtl/flag_offset_encoder_packer.sv
// Packs kept activations PACK_NUM per word: fill register feeding a single output register
// with valid/ready. A full fill register waits for the output register and stalls the input.
module flag_offset_packer
  import flag_offset_encoder_pkg::*;
#(
  parameter int unsigned ACT_WIDTH = DefActWidth,
  parameter int unsigned PACK_NUM  = DefPackNum
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr_i,
  input  logic                          push_i,
  input  logic [ACT_WIDTH-1:0]          push_dat_i,
  input  logic                          flush_i,
  input  logic                          word_rdy_i,
  output logic                          push_rdy_o,
  output logic                          drained_o,
  output logic [PACK_NUM*ACT_WIDTH-1:0] word_o,
  output logic                          word_val_o
);

  localparam int unsigned CntW  = $clog2(PACK_NUM + 1);
  localparam int unsigned SlotW = `C_LOG_2(PACK_NUM);

  logic [PACK_NUM-1:0][ACT_WIDTH-1:0] fill_q, fill_d;
  logic [CntW-1:0]                    fill_cnt_q, fill_cnt_d;
  logic [PACK_NUM*ACT_WIDTH-1:0]      out_q, out_d;
  logic                               out_val_q, out_val_d;
  logic                               out_free, fill_full, moved;

  always_comb begin
    out_free   = ~out_val_q | word_rdy_i;
    fill_full  = (fill_cnt_q == CntW'(PACK_NUM));
    push_rdy_o = ~(fill_full & ~out_free);
    drained_o  = (fill_cnt_q == '0) & out_free;
    fill_d     = fill_q;
    fill_cnt_d = fill_cnt_q;
    out_d      = out_q;
    out_val_d  = out_val_q & ~word_rdy_i;
    moved      = 1'b0;
    if (clr_i) begin
      fill_d     = '0;
      fill_cnt_d = '0;
      out_d      = '0;
      out_val_d  = 1'b0;
    end else begin
      // Slots are cleared on every move, so a flushed partial word is zero-padded.
      if (out_free && (fill_full || (flush_i && (fill_cnt_q != '0)))) begin
        out_d      = fill_q;
        out_val_d  = 1'b1;
        fill_d     = '0;
        fill_cnt_d = '0;
        moved      = 1'b1;
      end
      if (push_i && push_rdy_o) begin
        fill_d[fill_cnt_d[SlotW-1:0]] = push_dat_i;
        fill_cnt_d = fill_cnt_d + CntW'(1);
        if (!moved && out_free && (fill_cnt_d == CntW'(PACK_NUM))) begin
          out_d      = fill_d;
          out_val_d  = 1'b1;
          fill_d     = '0;
          fill_cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= '0;
      fill_cnt_q <= '0;
      out_q      <= '0;
      out_val_q  <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      fill_cnt_q <= fill_cnt_d;
      out_q      <= out_d;
      out_val_q  <= out_val_d;
    end
  end

  assign word_o     = out_q;
  assign word_val_o = out_val_q;

endmodule

// File: rtl/flag_offset_encoder.sv
// Sparsity encoder top: FSM, channel counter, flag accumulator and zero/threshold test.
// Define FLGOFFSET_ENC_THRESH_EN to add I_Thr magnitude pruning.
module flag_offset_encoder
  import flag_offset_encoder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ACT_WIDTH  = DefActWidth,
  parameter int unsigned PACK_NUM   = DefPackNum
) (
  input logic                  clk,
  input logic                  rst_n,
  flag_offset_encoder_if.slave bus
);

  localparam int unsigned    ChW    = `C_LOG_2(DATA_WIDTH);
  localparam logic [ChW-1:0] LastCh = ChW'(DATA_WIDTH - 1);

  enc_state_e            state_q, state_d;
  logic [ChW-1:0]        ch_q, ch_d, bit_idx;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] flag_q, flag_d;
  logic                  flag_val_q, flag_val_d;
  logic                  keep, beat, dat_rdy, push_rdy, drained;

`ifdef FLGOFFSET_ENC_THRESH_EN
  logic [ACT_WIDTH-1:0] mag;
  // The most negative code negates to itself, which as unsigned exceeds any threshold.
  always_comb begin
    mag  = bus.I_Dat[ACT_WIDTH-1] ? ((~bus.I_Dat) + ACT_WIDTH'(1)) : bus.I_Dat;
    keep = (mag > {1'b0, bus.I_Thr});
  end
`else
  assign keep = |bus.I_Dat;
`endif

  assign dat_rdy = (state_q == StCollect) & push_rdy;
  assign beat    = bus.I_Dat_val & dat_rdy & ~bus.I_Sta;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    acc_d      = acc_q;
    flag_d     = flag_q;
    flag_val_d = flag_val_q;
    bit_idx    = LastCh - ch_q;
    if (bus.I_Sta) begin
      state_d    = StCollect;
      ch_d       = '0;
      acc_d      = '0;
      flag_val_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StCollect: begin
          if (beat) begin
            if (keep) acc_d[bit_idx] = 1'b1;
            ch_d = ch_q + ChW'(1);
            if (ch_q == LastCh) begin
              ch_d    = '0;
              state_d = StFlush;
            end
          end
        end
        StFlush: begin
          if (drained) begin
            state_d    = StEmit;
            flag_d     = acc_q;
            flag_val_d = 1'b1;
          end
        end
        StEmit: begin
          if (flag_val_q && bus.I_Flag_rdy) begin
            state_d    = StCollect;
            flag_val_d = 1'b0;
            ch_d       = '0;
            acc_d      = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      acc_q      <= '0;
      flag_q     <= '0;
      flag_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      acc_q      <= acc_d;
      flag_q     <= flag_d;
      flag_val_q <= flag_val_d;
    end
  end

  flag_offset_packer #(
    .ACT_WIDTH (ACT_WIDTH),
    .PACK_NUM  (PACK_NUM)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (bus.I_Sta),
    .push_i     (beat & keep),
    .push_dat_i (bus.I_Dat),
    .flush_i    ((state_q == StFlush) & ~bus.I_Sta),
    .word_rdy_i (bus.I_Word_rdy),
    .push_rdy_o (push_rdy),
    .drained_o  (drained),
    .word_o     (bus.O_Word),
    .word_val_o (bus.O_Word_val)
  );

  assign bus.O_Dat_rdy  = dat_rdy;
  assign bus.O_Flag     = flag_q;
  assign bus.O_Flag_val = flag_val_q;
  assign bus.O_fnh      = (state_q == StIdle);

endmodule

// File: tb/tb_flag_offset_encoder.sv
// Bench for flag_offset_encoder: directed groups plus random groups checked against a
// group-level model (kept values -> packed words, then flag) in one ordered event queue.
module tb_flag_offset_encoder;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned PN = 4;

  typedef struct {
    bit          is_flag;
    logic [31:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flag_offset_encoder_if #(.DATA_WIDTH(DW), .ACT_WIDTH(AW), .PACK_NUM(PN)) bus ();

  flag_offset_encoder #(
    .DATA_WIDTH (DW),
    .ACT_WIDTH  (AW),
    .PACK_NUM   (PN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          beat_cnt = 0;
  int          word_mode = 1;
  int          flag_mode = 1;
  int          thr_val = 0;
  ev_t         exp_q[$];
  logic [31:0] obs_words[$];
  logic [31:0] obs_flags[$];
  logic [7:0]  grp[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit keep_val(input logic [7:0] v);
    int s;
    s = int'($signed(v));
`ifdef FLGOFFSET_ENC_THRESH_EN
    if (s < 0) s = -s;
    return s > thr_val;
`else
    return s != 0;
`endif
  endfunction

  // Expected events of one complete group: its packed words in order, then its flag.
  task automatic model_group(input logic [7:0] v[32]);
    logic [31:0] flag;
    logic [7:0]  kept[$];
    ev_t         e;
    flag = '0;
    for (int ch = 0; ch < 32; ch++) begin
      if (keep_val(v[ch])) begin
        flag[31-ch] = 1'b1;
        kept.push_back(v[ch]);
      end
    end
    for (int i = 0; i < kept.size(); i += 4) begin
      e.is_flag = 1'b0;
      e.val     = '0;
      for (int j = 0; j < 4; j++) if (i + j < kept.size()) e.val[8*j +: 8] = kept[i+j];
      exp_q.push_back(e);
    end
    e.is_flag = 1'b1;
    e.val     = flag;
    exp_q.push_back(e);
  endtask

  function automatic logic rdy_for(input int mode);
    if (mode == 2) return $urandom_range(0, 3) != 0;
    return mode == 1;
  endfunction

  always @(posedge clk) begin
    #1;
    bus.I_Word_rdy = rdy_for(word_mode);
    bus.I_Flag_rdy = rdy_for(flag_mode);
  end

  // Compare process: handshakes against the model queue, plus hold stability.
  logic        prev_wheld = 1'b0, prev_fheld = 1'b0;
  logic [31:0] prev_word = '0, prev_flag = '0;
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (prev_wheld) begin
        check("word_hold_val", bus.O_Word_val, 1);
        check("word_hold_dat", bus.O_Word, prev_word);
      end
      if (prev_fheld) begin
        check("flag_hold_val", bus.O_Flag_val, 1);
        check("flag_hold_dat", bus.O_Flag, prev_flag);
      end
      if (bus.O_Word_val && bus.I_Word_rdy) begin
        if (exp_q.size() == 0 || exp_q[0].is_flag) begin
          checks++;
          errors++;
          $display("FAIL word_order: got word 0x%08h, expected no word here", bus.O_Word);
        end else begin
          e = exp_q.pop_front();
          check("word", bus.O_Word, e.val);
        end
        obs_words.push_back(bus.O_Word);
      end
      if (bus.O_Flag_val && bus.I_Flag_rdy) begin
        if (exp_q.size() == 0 || !exp_q[0].is_flag) begin
          checks++;
          errors++;
          $display("FAIL flag_order: got flag 0x%08h, expected a word or nothing", bus.O_Flag);
        end else begin
          e = exp_q.pop_front();
          check("flag", bus.O_Flag, e.val);
        end
        obs_flags.push_back(bus.O_Flag);
      end
      prev_wheld = bus.O_Word_val & ~bus.I_Word_rdy & ~bus.I_Sta;
      prev_fheld = bus.O_Flag_val & ~bus.I_Flag_rdy & ~bus.I_Sta;
      prev_word  = bus.O_Word;
      prev_flag  = bus.O_Flag;
      if (bus.I_Dat_val && bus.O_Dat_rdy && !bus.I_Sta) beat_cnt++;
    end
  end

  // All driving tasks start and end 1 time unit after a rising edge.
  task automatic pulse_sta();
    bus.I_Sta = 1'b1;
    @(posedge clk); #1;
    bus.I_Sta = 1'b0;
  endtask

  task automatic send_group(input logic [7:0] v[32], input bit bubbles);
    int n;
    model_group(v);
`ifdef FLGOFFSET_ENC_THRESH_EN
    bus.I_Thr = thr_val[6:0];
`endif
    for (int ch = 0; ch < 32; ch++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          bus.I_Dat_val = 1'b0;
          bus.I_Dat     = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      bus.I_Dat_val = 1'b1;
      bus.I_Dat     = v[ch];
      n = 0;
      forever begin
        @(negedge clk);
        if (bus.O_Dat_rdy) break;
        n++;
        if (n > 500) begin
          check("beat_timeout", bus.O_Dat_rdy, 1);
          break;
        end
      end
      @(posedge clk); #1;
    end
    bus.I_Dat_val = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 3000) begin
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        break;
      end
    end
  endtask

  task automatic clear_obs();
    obs_words.delete();
    obs_flags.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, n;
    logic [31:0] held;
    bus.I_Sta      = 1'b0;
    bus.I_Dat_val  = 1'b0;
    bus.I_Dat      = '0;
    bus.I_Word_rdy = 1'b0;
    bus.I_Flag_rdy = 1'b0;
`ifdef FLGOFFSET_ENC_THRESH_EN
    bus.I_Thr      = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_fnh", bus.O_fnh, 1);
    check("rst_dat_rdy", bus.O_Dat_rdy, 0);
    check("rst_word_val", bus.O_Word_val, 0);
    check("rst_word", bus.O_Word, 0);
    check("rst_flag_val", bus.O_Flag_val, 0);
    check("rst_flag", bus.O_Flag, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_fnh", bus.O_fnh, 1);
    check("idle_dat_rdy", bus.O_Dat_rdy, 0);
    @(posedge clk); #1;

    // Ramp group: ch k = k.
    pulse_sta();
    check("start_fnh", bus.O_fnh, 0);
    for (int k = 0; k < 32; k++) grp[k] = 8'(k);
    clear_obs();
    send_group(grp, 1'b0);
    wait_drain();
    check("ramp_nwords", obs_words.size(), 8);
    if (obs_words.size() == 8) begin
      check("ramp_word0", obs_words[0], 32'h04030201);
      check("ramp_word7", obs_words[7], 32'h001F1E1D);
    end
    check("ramp_nflags", obs_flags.size(), 1);
    if (obs_flags.size() == 1) check("ramp_flag", obs_flags[0], 32'h7FFFFFFF);

    // All-zero group and flag latency.
    pulse_sta();
    for (int k = 0; k < 32; k++) grp[k] = 8'h00;
    clear_obs();
    send_group(grp, 1'b0);
    @(negedge clk);
    check("zero_flag_t1", bus.O_Flag_val, 0);
    @(negedge clk);
    check("zero_flag_t2", bus.O_Flag_val, 1);
    check("zero_flag_val", bus.O_Flag, 32'h0);
    @(posedge clk); #1;
    wait_drain();
    check("zero_nwords", obs_words.size(), 0);

    // Output stall: 0x05 everywhere, word ready low for 20 cycles.
    @(negedge clk);
    word_mode = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 32; k++) grp[k] = 8'h05;
    clear_obs();
    b0 = beat_cnt;
    fork
      send_group(grp, 1'b0);
      begin
        repeat (15) @(negedge clk);
        check("stall_beats", beat_cnt - b0, 8);
        check("stall_dat_rdy", bus.O_Dat_rdy, 0);
        repeat (5) @(negedge clk);
        word_mode = 1;
      end
    join
    wait_drain();
    check("stall_nwords", obs_words.size(), 8);
    foreach (obs_words[i]) check("stall_word", obs_words[i], 32'h05050505);

    // Abort a partial group, then even channels of 0x80.
    @(negedge clk);
    word_mode = 0;
    @(posedge clk); #1;
    pulse_sta();
    b0 = beat_cnt;
    for (int k = 0; k < 10; k++) begin
      bus.I_Dat_val = 1'b1;
      bus.I_Dat     = 8'h01;
      @(posedge clk); #1;
    end
    bus.I_Dat_val = 1'b0;
    @(negedge clk);
    check("abort_beats", beat_cnt - b0, 8);
    check("abort_word_held", bus.O_Word_val, 1);
    check("abort_dat_rdy", bus.O_Dat_rdy, 0);
    @(posedge clk); #1;
    pulse_sta();
    check("abort_word_val", bus.O_Word_val, 0);
    check("abort_dat_rdy_after", bus.O_Dat_rdy, 1);
    @(negedge clk);
    word_mode = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 32; k++) grp[k] = (k % 2 == 0) ? 8'h80 : 8'h00;
    clear_obs();
    send_group(grp, 1'b0);
    wait_drain();
    check("even_nwords", obs_words.size(), 4);
    foreach (obs_words[i]) check("even_word", obs_words[i], 32'h80808080);
    if (obs_flags.size() == 1) check("even_flag", obs_flags[0], 32'hAAAAAAAA);
    else check("even_nflags", obs_flags.size(), 1);

    // Flag back-pressure in EMIT.
    @(negedge clk);
    flag_mode = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 32; k++) grp[k] = 8'($urandom);
    send_group(grp, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.O_Flag_val && n < 200);
    check("emit_flag_seen", bus.O_Flag_val, 1);
    held = bus.O_Flag;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("emit_flag_stable", bus.O_Flag, held);
      check("emit_dat_rdy", bus.O_Dat_rdy, 0);
    end
    flag_mode = 1;
    @(negedge clk);
    check("emit_handshake", bus.O_Flag_val & bus.I_Flag_rdy, 1);
    @(negedge clk);
    check("emit_next_group", bus.O_Dat_rdy, 1);
    @(posedge clk); #1;
    wait_drain();

`ifdef FLGOFFSET_ENC_THRESH_EN
    // Magnitude pruning with threshold 2.
    thr_val = 2;
    pulse_sta();
    for (int k = 0; k < 32; k++) grp[k] = 8'h00;
    grp[0] = 8'h01;
    grp[1] = 8'hFE;
    grp[2] = 8'h03;
    grp[3] = 8'hFD;
    clear_obs();
    send_group(grp, 1'b0);
    wait_drain();
    check("thr_nwords", obs_words.size(), 1);
    if (obs_words.size() == 1) check("thr_word", obs_words[0], 32'h0000FD03);
    if (obs_flags.size() == 1) check("thr_flag", obs_flags[0], 32'h30000000);
    else check("thr_nflags", obs_flags.size(), 1);
`endif

    // Random groups with bubbles and random back-pressure.
    @(negedge clk);
    word_mode = 2;
    flag_mode = 2;
    @(posedge clk); #1;
    pulse_sta();
    for (int g = 0; g < 16; g++) begin
`ifdef FLGOFFSET_ENC_THRESH_EN
      thr_val = int'($urandom_range(0, 5));
`endif
      for (int k = 0; k < 32; k++) grp[k] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      send_group(grp, 1'b1);
    end
    wait_drain();
    @(negedge clk);
    word_mode = 1;
    flag_mode = 1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
